// File: rtl/pipe_stage_sequencer.sv
// Sequencer for a STAGES-deep registered datapath: frame intake,
// per-stage valid tracking and enables, drain and done pulse.
module pipe_stage_sequencer #(
   parameter int STAGES = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  frame_len,
   input  logic              hold,
   output logic              busy,
   output logic              in_take,
   output logic [CNT_W-1:0]  sample_idx,
   output logic [STAGES-1:0] stage_en,
   output logic              out_valid,
   output logic              done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [STAGES-1:0] vld_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  len_q;
   logic [CNT_W-1:0]  idx_q;
   logic              accept;

   assign accept    = (state_q == IDLE) && start && !hold;
   assign busy      = (state_q != IDLE);
   assign in_take   = (state_q == LOAD) && !hold;
   assign done      = (state_q == DONE);
   assign out_valid = vld_q[STAGES-1];
   // idx_q remembers the last taken index so the output holds between takes
   assign sample_idx = in_take ? cnt_q : idx_q;

   always_comb begin
      stage_en    = '0;
      stage_en[0] = in_take;
      for (int i = 1; i < STAGES; i++)
         stage_en[i] = vld_q[i-1] & ~hold;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept)
               state_d = (frame_len != '0) ? LOAD : DONE;
         end
         LOAD: begin
            if (!hold && cnt_q == len_q - CNT_W'(1))
               state_d = DRAIN;
         end
         DRAIN: begin
            if (!hold && vld_q[STAGES-2:0] == '0)
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vld_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         if (!hold)
            vld_q <= {vld_q[STAGES-2:0], in_take};
         if (accept && frame_len != '0) begin
            len_q <= frame_len;
            cnt_q <= '0;
         end
         if (in_take) begin
            cnt_q <= cnt_q + CNT_W'(1);
            idx_q <= cnt_q;
         end
      end
   end

endmodule
